// File: rtl/myadder1_example_pkg.sv
// Shared types and constants for the vadd stream checker: FSM states, lane width and LFSR setup.
package myadder1_example_pkg;

  localparam int LANE_W = 32;

  typedef enum logic [1:0] {IDLE, CHECK, FLUSH, DONE} state_t;

  // Galois form of x^16+x^14+x^13+x^11, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int lanes(input int w);
    return w / LANE_W;
  endfunction

endpackage

// File: rtl/myadder1_example_stream_checker_if.sv
// AXI4-Stream bundle between the adder output and the checker sink.
interface myadder1_example_stream_checker_if #(
  parameter int W = 512
) ();

  logic           tvalid;
  logic           tready;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tkeep;
  logic           tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/myadder1_example_lfsr16.sv
// 16-bit LFSR used to pseudo-randomly throttle tready; holds its seed when disabled.
module myadder1_example_lfsr16
  import myadder1_example_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bit
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_en) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_bit = r_lfsr[0];

endmodule

// File: rtl/myadder1_example_stream_checker.sv
// Stream sink that checks every 32-bit lane against beat*LANES+lane+constant and reports
// beat count, lane-error count, first failing beat and framing errors for one packet.
module myadder1_example_stream_checker
  import myadder1_example_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH    = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384,
  parameter int C_TREADY_THROTTLE    = 0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [C_ADDER_BIT_WIDTH-1:0] i_ctrl_constant,
  input  logic                         i_ap_start,
  output logic                         o_ap_done,
  myadder1_example_stream_checker_if.slave s_axis,
  output logic [31:0]                  o_beat_count,
  output logic [31:0]                  o_err_count,
  output logic [31:0]                  o_first_err_beat,
  output logic                         o_framing_err
);

  localparam int W      = C_S_AXIS_TDATA_WIDTH;
  localparam int LANES  = lanes(W);
  localparam int NBEATS = C_LENGTH_IN_BYTES / (W / 8);
  localparam logic [31:0] LAST_BEAT = 32'(NBEATS - 1);

  state_t                       r_state;
  logic [C_ADDER_BIT_WIDTH-1:0] r_const;
  logic                         r_s1_valid;
  logic [W-1:0]                 r_s1_data;
  logic [31:0]                  r_s1_beat;
  logic                         r_s1_last;
  logic                         r_s1_keep_ok;
  logic [31:0]                  r_beat_count;
  logic [31:0]                  r_err_count;
  logic [31:0]                  r_first_err;
  logic                         r_framing;
  logic                         r_done;

  logic                         w_lfsr_bit;
  logic                         w_accept;
  logic [LANES-1:0]             w_mismatch;
  logic [31:0]                  w_popcount;
  logic [32:0]                  w_err_sum;
  logic [31:0]                  w_err_next;
  logic                         w_frame_bad;

  myadder1_example_lfsr16 u_lfsr (
    .clk   (aclk),
    .rst   (areset),
    .i_en  (C_TREADY_THROTTLE != 0),
    .o_bit (w_lfsr_bit)
  );

  // tready is a function of registered state only, never of tvalid.
  assign s_axis.tready = (r_state == CHECK) && ((C_TREADY_THROTTLE == 0) || w_lfsr_bit);
  assign w_accept      = s_axis.tvalid && s_axis.tready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] w_expected;
    assign w_expected     = LANE_W'(r_s1_beat * 32'(LANES) + 32'(gi)) + r_const;
    assign w_mismatch[gi] = r_s1_data[gi*LANE_W +: LANE_W] != w_expected;
  end

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < LANES; i++) begin
      w_popcount = w_popcount + 32'(w_mismatch[i]);
    end
  end

  // Error count clamps at all ones instead of wrapping.
  assign w_err_sum   = {1'b0, r_err_count} + {1'b0, w_popcount};
  assign w_err_next  = w_err_sum[32] ? '1 : w_err_sum[31:0];
  assign w_frame_bad = (r_s1_last != (r_s1_beat == LAST_BEAT)) || !r_s1_keep_ok;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= IDLE;
      r_const      <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_beat    <= '0;
      r_s1_last    <= 1'b0;
      r_s1_keep_ok <= 1'b0;
      r_beat_count <= '0;
      r_err_count  <= '0;
      r_first_err  <= '1;
      r_framing    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data    <= s_axis.tdata;
        r_s1_beat    <= r_beat_count;
        r_s1_last    <= s_axis.tlast;
        r_s1_keep_ok <= &s_axis.tkeep;
        r_beat_count <= r_beat_count + 32'd1;
      end
      if (r_s1_valid) begin
        r_err_count <= w_err_next;
        if ((r_first_err == '1) && (w_popcount != '0)) begin
          r_first_err <= r_s1_beat;
        end
        if (w_frame_bad) begin
          r_framing <= 1'b1;
        end
      end
      // FLUSH gives the last beat's compare stage one cycle before ap_done.
      case (r_state)
        IDLE: begin
          if (i_ap_start) begin
            r_state      <= CHECK;
            r_const      <= i_ctrl_constant;
            r_beat_count <= '0;
            r_err_count  <= '0;
            r_first_err  <= '1;
            r_framing    <= 1'b0;
          end
        end
        CHECK: begin
          if (w_accept && (r_beat_count == LAST_BEAT)) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_ap_done        = r_done;
  assign o_beat_count     = r_beat_count;
  assign o_err_count      = r_err_count;
  assign o_first_err_beat = r_first_err;
  assign o_framing_err    = r_framing;

endmodule

// File: tb/tb_myadder1_example_stream_checker.sv
// Scoreboard bench: one unthrottled and one throttled checker, random stimulus, expected run
// reports derived from the packet contents and queued per DUT until its ap_done pulse.
module tb_myadder1_example_stream_checker;

  localparam int W           = 512;
  localparam int KW          = W / 8;
  localparam int LANES       = W / 32;
  localparam int NBEATS      = 16384 / KW;
  localparam int CYCLE_LIMIT = 4000;

  typedef struct {
    logic [31:0] beats;
    logic [31:0] errs;
    logic [31:0] firstErr;
    logic        framing;
  } expect_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [31:0]   ctrlConst [2];
  logic          apStart [2];
  logic          apDone [2];
  logic          tvalid [2];
  logic          tready [2];
  logic [W-1:0]  tdata [2];
  logic [KW-1:0] tkeep [2];
  logic          tlast [2];
  logic [31:0]   beatCount [2];
  logic [31:0]   errCount [2];
  logic [31:0]   firstErrBeat [2];
  logic          framingErr [2];

  int      nCompared = 0;
  int      nMismatched = 0;
  expect_t expQ0 [$];
  expect_t expQ1 [$];

  always #5 aclk = ~aclk;

  myadder1_example_stream_checker_if #(.W(W)) axisIf0 ();
  myadder1_example_stream_checker_if #(.W(W)) axisIf1 ();

  assign axisIf0.tvalid = tvalid[0];
  assign axisIf0.tdata  = tdata[0];
  assign axisIf0.tkeep  = tkeep[0];
  assign axisIf0.tlast  = tlast[0];
  assign tready[0]      = axisIf0.tready;
  assign axisIf1.tvalid = tvalid[1];
  assign axisIf1.tdata  = tdata[1];
  assign axisIf1.tkeep  = tkeep[1];
  assign axisIf1.tlast  = tlast[1];
  assign tready[1]      = axisIf1.tready;

  myadder1_example_stream_checker #(.C_S_AXIS_TDATA_WIDTH(W), .C_TREADY_THROTTLE(0)) dut0 (
    .aclk(aclk), .areset(areset), .i_ctrl_constant(ctrlConst[0]), .i_ap_start(apStart[0]),
    .o_ap_done(apDone[0]), .s_axis(axisIf0.slave), .o_beat_count(beatCount[0]),
    .o_err_count(errCount[0]), .o_first_err_beat(firstErrBeat[0]), .o_framing_err(framingErr[0])
  );

  myadder1_example_stream_checker #(.C_S_AXIS_TDATA_WIDTH(W), .C_TREADY_THROTTLE(1)) dut1 (
    .aclk(aclk), .areset(areset), .i_ctrl_constant(ctrlConst[1]), .i_ap_start(apStart[1]),
    .o_ap_done(apDone[1]), .s_axis(axisIf1.slave), .o_beat_count(beatCount[1]),
    .o_err_count(errCount[1]), .o_first_err_beat(firstErrBeat[1]), .o_framing_err(framingErr[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input int d, input string tag);
    checkOutput($sformatf("%s dut%0d tready", tag, d), {31'b0, tready[d]}, 32'd0);
    checkOutput($sformatf("%s dut%0d ap_done", tag, d), {31'b0, apDone[d]}, 32'd0);
    checkOutput($sformatf("%s dut%0d beat_count", tag, d), beatCount[d], 32'd0);
    checkOutput($sformatf("%s dut%0d err_count", tag, d), errCount[d], 32'd0);
    checkOutput($sformatf("%s dut%0d first_err_beat", tag, d), firstErrBeat[d], 32'hFFFF_FFFF);
    checkOutput($sformatf("%s dut%0d framing_err", tag, d), {31'b0, framingErr[d]}, 32'd0);
  endtask

  // Monitor: every ap_done pops the oldest expected report for that DUT.
  always @(negedge aclk) begin
    for (int d = 0; d < 2; d++) begin
      if (apDone[d] === 1'b1) begin
        expect_t e;
        int qSize;
        qSize = (d == 0) ? expQ0.size() : expQ1.size();
        if (qSize == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL dut%0d unexpected ap_done: got 1 expected 0", d);
        end else begin
          if (d == 0) e = expQ0.pop_front();
          else        e = expQ1.pop_front();
          checkOutput($sformatf("dut%0d beat_count", d), beatCount[d], e.beats);
          checkOutput($sformatf("dut%0d err_count", d), errCount[d], e.errs);
          checkOutput($sformatf("dut%0d first_err_beat", d), firstErrBeat[d], e.firstErr);
          checkOutput($sformatf("dut%0d framing_err", d), {31'b0, framingErr[d]}, {31'b0, e.framing});
          checkOutput($sformatf("dut%0d tready at done", d), {31'b0, tready[d]}, 32'd0);
        end
      end
    end
  end

  // One packet: start, stream NBEATS beats, push the report the packet should produce.
  task automatic applyStimulus(input int d, input logic [31:0] cst, input int corruptBeat,
                               input int corruptLane, input int earlyLast, input bit dropLast,
                               input int badKeepBeat, input bit gaps, input bit randErr,
                               input int resetAt);
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic [31:0]   want;
    expect_t       e;
    int            b, cycles, idx, qSize;
    bit            built, acc, v;
    e.beats = NBEATS; e.errs = 0; e.firstErr = 32'hFFFF_FFFF; e.framing = 1'b0;
    data = '0; keep = '1; last = 1'b0;
    @(posedge aclk); #1;
    ctrlConst[d] = cst;
    apStart[d] = 1'b1;
    @(posedge aclk); #1;
    apStart[d] = 1'b0;
    b = 0; cycles = 0; built = 1'b0;
    while (b < NBEATS && cycles < CYCLE_LIMIT) begin
      if (b == resetAt) begin
        areset = 1'b1;
        tvalid[d] = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        return;
      end
      if (!built) begin
        for (int l = 0; l < LANES; l++) data[l*32 +: 32] = 32'(b * LANES + l) + cst;
        if (b == corruptBeat) data[corruptLane*32] = ~data[corruptLane*32];
        if (randErr && $urandom_range(0, 15) == 0) begin
          idx = $urandom_range(0, LANES - 1) * 32 + $urandom_range(0, 31);
          data[idx] = ~data[idx];
        end
        keep = (b == badKeepBeat) ? {{(KW-1){1'b1}}, 1'b0} : '1;
        last = (b == NBEATS - 1);
        if (b == earlyLast) last = 1'b1;
        if (dropLast && b == NBEATS - 1) last = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          want = 32'(b * LANES + l) + cst;
          if (data[l*32 +: 32] !== want) begin
            e.errs++;
            if (e.firstErr == 32'hFFFF_FFFF) e.firstErr = b;
          end
        end
        if ((last != (b == NBEATS - 1)) || (keep != '1)) e.framing = 1'b1;
        built = 1'b1;
      end
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      tvalid[d] = v;
      tdata[d]  = v ? data : {LANES{$urandom()}};
      tkeep[d]  = keep;
      tlast[d]  = last;
      @(negedge aclk);
      acc = v && (tready[d] === 1'b1);
      @(posedge aclk); #1;
      if (acc) begin
        b++;
        built = 1'b0;
      end
      cycles++;
    end
    tvalid[d] = 1'b0;
    if (b < NBEATS) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL dut%0d stream stall: got %0d beats expected %0d", d, b, NBEATS);
      return;
    end
    if (d == 0) expQ0.push_back(e);
    else        expQ1.push_back(e);
    cycles = 0;
    qSize = 1;
    while (qSize != 0 && cycles < 50) begin
      @(posedge aclk); #1;
      qSize = (d == 0) ? expQ0.size() : expQ1.size();
      cycles++;
    end
    if (qSize != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL dut%0d ap_done timeout: got 0 expected 1", d);
      if (d == 0) expQ0.delete();
      else        expQ1.delete();
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ctrlConst[d] = '0; apStart[d] = 1'b0; tvalid[d] = 1'b0;
      tdata[d] = '0; tkeep[d] = '1; tlast[d] = 1'b0;
    end
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    checkIdleOutputs(0, "reset");
    checkIdleOutputs(1, "reset");

    applyStimulus(0, 32'd5, -1, -1, -1, 1'b0, -1, 1'b0, 1'b0, -1);
    applyStimulus(0, 32'd5, 10, 3, -1, 1'b0, -1, 1'b0, 1'b0, -1);
    applyStimulus(0, 32'd5, -1, -1, 100, 1'b1, -1, 1'b0, 1'b0, -1);
    applyStimulus(0, 32'hFFFF_FFFF, -1, -1, -1, 1'b0, -1, 1'b0, 1'b0, -1);
    applyStimulus(0, 32'hFFFF_FFFF, 0, 1, -1, 1'b0, -1, 1'b0, 1'b0, -1);
    applyStimulus(0, $urandom(), -1, -1, -1, 1'b0, 7, 1'b1, 1'b0, -1);
    applyStimulus(0, $urandom(), -1, -1, -1, 1'b0, -1, 1'b1, 1'b1, -1);

    applyStimulus(0, 32'd5, 20, 2, -1, 1'b0, -1, 1'b0, 1'b0, 128);
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    checkIdleOutputs(0, "after mid-run reset");
    applyStimulus(0, 32'd5, -1, -1, -1, 1'b0, -1, 1'b0, 1'b0, -1);

    applyStimulus(1, 32'd5, -1, -1, -1, 1'b0, -1, 1'b1, 1'b0, -1);
    applyStimulus(1, $urandom(), -1, -1, -1, 1'b0, -1, 1'b1, 1'b1, -1);
    applyStimulus(1, $urandom(), NBEATS - 1, LANES - 1, -1, 1'b0, -1, 1'b1, 1'b0, -1);

    repeat (5) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
